// File: rtl/seq_shift_add_core.sv
// Sequential 8x8 shift-and-add magnitude multiplier with sign fix-up stage.
// Optional macro SEQ_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module seq_shift_add_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mcand_mag,
  input  logic [7:0]  mplier_mag,
  input  logic        neg,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_mcand;
  logic [7:0]  r_mplier;
  logic        r_neg;
  logic [15:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_product;

  logic        w_accept;
  logic        w_run;
  logic        w_fix;
  logic        w_last;
  logic [7:0]  w_mplier_sh;
  logic [15:0] w_addend;
  logic [15:0] w_acc_nxt;
  logic [15:0] w_signed;

  // Next-state decode and datapath arithmetic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    w_fix       = 1'b0;
    w_mplier_sh = r_mplier >> 1;
    w_addend    = {8'h00, r_mcand} << r_cnt;
    w_acc_nxt   = r_acc + (r_mplier[0] ? w_addend : '0);
    // Negating zero yields zero in 16-bit arithmetic, so no negative-zero case exists
    w_signed    = r_neg ? (16'h0000 - r_acc) : r_acc;
`ifdef SEQ_MUL_EARLY_TERM_EN
    w_last      = (r_cnt == 3'd7) || (w_mplier_sh == '0);
`else
    w_last      = (r_cnt == 3'd7);
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mcand  <= mcand_mag;
        r_mplier <= mplier_mag;
        r_neg    <= neg;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
      if (w_run) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= w_mplier_sh;
        r_cnt    <= r_cnt + 3'd1;
      end
      if (w_fix) begin
        r_product <= w_signed;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_core.sv
// Directed self-checking bench for seq_shift_add_core; honours SEQ_MUL_EARLY_TERM_EN for latency expectations.
module tb_seq_shift_add_core;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand_mag;
  logic [7:0]  mplier_mag;
  logic        neg;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_checks;
  int n_fail;

  seq_shift_add_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mcand_mag  (mcand_mag),
    .mplier_mag (mplier_mag),
    .neg        (neg),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Edges from accepted start to done: fixed 9, or RUN count set by the top multiplier bit plus FIX
  function automatic int exp_latency(input logic [7:0] mp);
`ifdef SEQ_MUL_EARLY_TERM_EN
    int runs;
    runs = 1;
    for (int unsigned i = 0; i < 8; i++)
      if (mp[i]) runs = int'(i) + 1;
    return runs + 1;
`else
    return 9;
`endif
  endfunction

  // Drives start now; ign_a/ign_b are edge offsets at which a stray start is sampled.
  // With chain=1 it returns in the done cycle so the caller can issue the next start there.
  task automatic run_op(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                        input logic ng, input logic [15:0] exp_p,
                        input int ign_a, input int ign_b, input bit chain);
    int   lat;
    int   exp_lat;
    logic seen;
    exp_lat    = exp_latency(mp);
    mcand_mag  = mc;
    mplier_mag = mp;
    neg        = ng;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    mcand_mag  = 8'hFF;
    mplier_mag = 8'hFF;
    neg        = ~ng;
    check_eq({tag, "_busy_on_accept"}, {14'b0, done, busy}, 16'h0001);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      start = (lat + 1 == ign_a) || (lat + 1 == ign_b);
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (lat < exp_lat)
        check_eq({tag, "_busy_mid"}, {14'b0, done, busy}, 16'h0001);
    end
    start = 1'b0;
    if (!seen) begin
      check_eq({tag, "_done_timeout"}, 16'h0000, 16'h0001);
    end else begin
      check_eq({tag, "_latency"}, 16'(lat), 16'(exp_lat));
      check_eq({tag, "_busy_at_done"}, {15'b0, busy}, 16'h0000);
      check_eq({tag, "_product"}, product, exp_p);
      if (!chain) begin
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse_one"}, {15'b0, done}, 16'h0000);
        check_eq({tag, "_product_held"}, product, exp_p);
      end
    end
  endtask

  initial begin
    int dones;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    mcand_mag  = 8'h00;
    mplier_mag = 8'h00;
    neg        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy",    {15'b0, busy}, 16'h0000);
    check_eq("reset_done",    {15'b0, done}, 16'h0000);
    check_eq("reset_product", product,       16'h0000);

    // First start coincides with the first edge that sees rst_n high
    @(negedge clk);
    rst_n = 1'b1;
    run_op("m7x3n",    8'h07, 8'h03, 1'b1, 16'hFFEB, 0, 0, 1'b0);
    run_op("m80x80p",  8'h80, 8'h80, 1'b0, 16'h4000, 0, 0, 1'b0);
    run_op("m80x80n",  8'h80, 8'h80, 1'b1, 16'hC000, 0, 0, 1'b0);
    run_op("m0x55n",   8'h00, 8'h55, 1'b1, 16'h0000, 0, 0, 1'b0);
    run_op("mAxB_ign", 8'h0A, 8'h0B, 1'b0, 16'h006E, 3, 5, 1'b0);
    run_op("m9x1",     8'h09, 8'h01, 1'b0, 16'h0009, 0, 0, 1'b0);

    // Back-to-back: new start in the done cycle
    run_op("m5x6",     8'h05, 8'h06, 1'b0, 16'h001E, 0, 0, 1'b1);
    run_op("mFxF_b2b", 8'h0F, 8'h0F, 1'b1, 16'hFF1F, 0, 0, 1'b0);

    // Reset at edge N+4 of a running multiply
    run_op("mAxB_pre", 8'h0A, 8'h0B, 1'b0, 16'h006E, 0, 0, 1'b0);
    mcand_mag  = 8'h0A;
    mplier_mag = 8'h0B;
    neg        = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy",    {15'b0, busy}, 16'h0000);
    check_eq("abort_done",    {15'b0, done}, 16'h0000);
    check_eq("abort_product", product,       16'h0000);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("abort_no_done", 16'(dones), 16'h0000);
    check_eq("abort_product_after", product, 16'h0000);
    run_op("mCxD_post", 8'h0C, 8'h0D, 1'b0, 16'h009C, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_core.md
SEQ_SHIFT_ADD_CORE -- requirements
Module: seq_shift_add_core

Interface
REQ-001 The block SHALL have the port: clk  input  1  rising-edge clock; sole clock domain.
REQ-002 The block SHALL have the port: rst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-003 The block SHALL have the port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-004 The block SHALL have the port: mcand_mag  input  8  unsigned multiplicand magnitude, 0..128, supplied by the upstream two's-complement stage.
REQ-005 The block SHALL have the port: mplier_mag  input  8  unsigned multiplier magnitude, 0..128, supplied by the upstream two's-complement stage.
REQ-006 The block SHALL have the port: neg  input  1  product sign, equal to the XOR of the original operand sign bits.
REQ-007 The block SHALL have the port: busy  output  1  high while a multiplication is in progress.
REQ-008 The block SHALL have the port: done  output  1  single-cycle pulse when product becomes valid.
REQ-009 The block SHALL have the port: product  output  16  signed two's-complement result, held until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-011 In IDLE with start=1, on the clock edge: latch mcand_mag, mplier_mag and neg; clear the 16-bit accumulator; clear the 3-bit bit counter; set busy=1; go to RUN.
REQ-012 In each RUN cycle: if the multiplier register LSB is 1, add the zero-extended multiplicand shifted left by the counter value to the accumulator; shift the multiplier register right by 1; increment the counter.
REQ-013 RUN SHALL go to FIX after the cycle in which the counter equals 7, giving 8 RUN cycles.
REQ-014 In FIX, on the clock edge: set product to the two's complement of the accumulator if neg=1, otherwise to the accumulator; pulse done=1 for one cycle; set busy=0; go to IDLE.
REQ-015 Latency with the macro absent SHALL be fixed: start sampled at edge N gives done=1 and a valid product after edge N+9.
REQ-016 Arithmetic: all sums SHALL be unsigned 16-bit; the maximum magnitude product 128*128=0x4000 SHALL fit without overflow; negation SHALL be 16-bit.
REQ-017 A zero accumulator with neg=1 SHALL yield product 0x0000; negative zero is not allowed.
REQ-018 start asserted while busy=1 SHALL be ignored and SHALL NOT alter the latched operands.
REQ-019 start=1 in the cycle done=1 (state IDLE) SHALL be accepted as a new operation.
REQ-020 The input ports SHALL be don't-care except in the cycle start is accepted.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force state IDLE, busy=0, done=0, product=0x0000, and clear the accumulator, counter and operand registers.
REQ-022 Reset asserted mid-operation (RUN or FIX) SHALL abort the operation with no done pulse, and the product SHALL read 0x0000 afterwards.
REQ-023 The first start SHALL be accepted at the first clock edge with rst_n=1.

Configuration
REQ-024 The macro SEQ_MUL_EARLY_TERM_EN SHALL, when defined, make RUN go to FIX after any RUN cycle whose shifted multiplier register is zero, in addition to the counter=7 exit.
REQ-025 With SEQ_MUL_EARLY_TERM_EN defined, the minimum latency SHALL be 2 cycles (one RUN cycle and one FIX cycle) and the product value SHALL be identical to the macro-absent result.
REQ-026 With SEQ_MUL_EARLY_TERM_EN undefined, latency SHALL always be 9 cycles, per REQ-015.

Verification
REQ-027 The bench SHALL cover: mcand_mag=0x07, mplier_mag=0x03, neg=1, start at edge N -> done after edge N+9, product=0xFFEB (-21), busy high for cycles N+1..N+9.
REQ-028 The bench SHALL cover: mcand_mag=0x80, mplier_mag=0x80, neg=0 -> product=0x4000; the same operands with neg=1 -> product=0xC000.
REQ-029 The bench SHALL cover: mcand_mag=0x00, mplier_mag=0x55, neg=1 -> product=0x0000.
REQ-030 The bench SHALL cover: start pulsed at cycles N+3 and N+5 of an active 0x0A*0x0B run -> ignored, product=0x006E, exactly one done pulse.
REQ-031 The bench SHALL cover: rst_n=0 at cycle N+4 of an active run -> busy=0, done never pulses, product=0x0000, and the next start completes normally.
REQ-032 The bench SHALL cover: mcand_mag=0x09, mplier_mag=0x01, neg=0 -> product=0x0009, with done after edge N+2 when SEQ_MUL_EARLY_TERM_EN is defined and after edge N+9 when it is undefined.
